// File: rtl/mult_unit_64.sv
// 64-bit iterative radix-2 shift-add multiplier (MUL / SMULH / UMULH).
// A start in IDLE produces one done pulse 66 cycles later; result and WriteRegister hold until the next result.
module mult_unit_64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [63:0] A,
  input  logic [63:0] B,
  input  logic [4:0]  Rd,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [4:0]  WriteRegister,
  output logic        RegWrite
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_SMULH = 2'b01;
  localparam logic [1:0] OP_UMULH = 2'b10;

  logic [1:0]   r_state;
  logic [5:0]   r_cnt;
  logic [127:0] r_acc;
  logic [63:0]  r_mcand;
  logic [1:0]   r_op;
  logic         r_neg;
  logic [4:0]   r_rd;
  logic [63:0]  r_result;
  logic [4:0]   r_wreg;
  logic         r_busy;
  logic         r_done;

  logic [1:0]   w_next_state;
  logic         w_is_smulh;
  logic [63:0]  w_abs_a;
  logic [63:0]  w_abs_b;
  logic [64:0]  w_sum;
  logic [127:0] w_step;
  logic [127:0] w_fixed;
  logic [63:0]  w_sel;

  // Operand conditioning, one shift-add step and the final sign fix-up.
  always_comb begin
    w_is_smulh = (op == OP_SMULH);
    w_abs_a    = (w_is_smulh && A[63]) ? (~A + 64'd1) : A;
    w_abs_b    = (w_is_smulh && B[63]) ? (~B + 64'd1) : B;
    w_sum      = {1'b0, r_acc[127:64]} + {1'b0, r_mcand};
    // The multiplier sits in the low half and drains out as the product shifts in from the top.
    if (r_acc[0]) begin
      w_step = {w_sum, r_acc[63:1]};
    end else begin
      w_step = {1'b0, r_acc[127:1]};
    end
    if (r_neg) begin
      w_fixed = ~r_acc + 128'd1;
    end else begin
      w_fixed = r_acc;
    end
    if ((r_op == OP_SMULH) || (r_op == OP_UMULH)) begin
      w_sel = w_fixed[127:64];
    end else begin
      w_sel = w_fixed[63:0];
    end
  end

  // Next-state selection.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next_state = S_CALC;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_cnt == 6'd63) begin
          w_next_state = S_FIX;
        end else begin
          w_next_state = S_CALC;
        end
      end
      S_FIX:   w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_acc    <= 128'd0;
      r_mcand  <= 64'd0;
      r_op     <= 2'd0;
      r_neg    <= 1'b0;
      r_rd     <= 5'd0;
      r_result <= 64'd0;
      r_wreg   <= 5'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_rd    <= Rd;
            r_mcand <= w_abs_b;
            r_acc   <= {64'd0, w_abs_a};
            r_neg   <= w_is_smulh & (A[63] ^ B[63]);
            r_cnt   <= 6'd0;
          end
        end
        S_CALC: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 6'd1;
        end
        S_FIX: begin
          r_acc    <= w_fixed;
          r_result <= w_sel;
          r_wreg   <= r_rd;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign RegWrite      = r_done;
  assign result        = r_result;
  assign WriteRegister = r_wreg;

endmodule

// File: tb/tb_mult_unit_64.sv
// Randomized self-checking bench for mult_unit_64 against a countdown/arithmetic reference model.
module tb_mult_unit_64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [63:0] A = 64'd0;
  logic [63:0] B = 64'd0;
  logic [4:0]  Rd = 5'd0;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic [4:0]  WriteRegister;
  logic        RegWrite;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  // Reference model state: cycles until idle, pending and visible results.
  int          m_cnt = 0;
  logic [63:0] m_pend = 64'd0;
  logic [4:0]  m_pend_rd = 5'd0;
  logic [63:0] m_result = 64'd0;
  logic [4:0]  m_wreg = 5'd0;

  mult_unit_64 dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B), .Rd(Rd),
    .busy(busy), .done(done), .result(result), .WriteRegister(WriteRegister),
    .RegWrite(RegWrite)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sb, sp;
    logic [127:0] up;
    case (o)
      2'b01: begin
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        sp = sa * sb;
        return sp[127:64];
      end
      2'b10: begin
        up = {64'd0, a} * {64'd0, b};
        return up[127:64];
      end
      default: return a * b;
    endcase
  endfunction

  // Model: accepted start -> 66 cycles busy, result visible in the last (done) cycle.
  always @(posedge clk) begin
    if (reset) begin
      m_cnt    <= 0;
      m_result <= 64'd0;
      m_wreg   <= 5'd0;
    end else if (m_cnt == 0) begin
      if (start) begin
        m_pend    <= ref_mul(op, A, B);
        m_pend_rd <= Rd;
        m_cnt     <= 66;
      end
    end else begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 2) begin
        m_result <= m_pend;
        m_wreg   <= m_pend_rd;
      end
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (check_en) begin
      n_checks += 3;
      if (busy !== (m_cnt > 0)) begin
        n_fail++;
        $display("FAIL busy t=%0t got=%b want=%b", $time, busy, (m_cnt > 0));
      end
      if (done !== (m_cnt == 1)) begin
        n_fail++;
        $display("FAIL done t=%0t got=%b want=%b", $time, done, (m_cnt == 1));
      end
      if (RegWrite !== (m_cnt == 1)) begin
        n_fail++;
        $display("FAIL RegWrite t=%0t got=%b want=%b", $time, RegWrite, (m_cnt == 1));
      end
      if (m_cnt <= 1) begin
        n_checks += 2;
        if (result !== m_result) begin
          n_fail++;
          $display("FAIL result t=%0t got=%h want=%h", $time, result, m_result);
        end
        if (WriteRegister !== m_wreg) begin
          n_fail++;
          $display("FAIL WriteRegister t=%0t got=%0d want=%0d", $time, WriteRegister, m_wreg);
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (m_cnt != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (m_cnt != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle timeout");
    end
  endtask

  // Issue one op, optionally with an ignored start pulse at CALC cycle 10, then wait for done.
  task automatic do_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, input bit chk_lit, input logic [63:0] lit,
                       input bit noise);
    bit seen = 1'b0;
    wait_idle();
    start = 1'b1; op = o; A = a; B = b; Rd = rd;
    @(posedge clk); #1;
    start = 1'b0;
    op = 2'($urandom_range(3, 0)); A = {$urandom, $urandom}; B = {$urandom, $urandom}; Rd = 5'($urandom);
    if (noise) begin
      repeat (10) @(posedge clk);
      #1;
      start = 1'b1; A = 64'd9; B = 64'd9;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout op=%0d", o);
    end else if (chk_lit) begin
      n_checks++;
      if (result !== lit) begin
        n_fail++;
        $display("FAIL literal op=%0d got=%h want=%h", o, result, lit);
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] pick_operand();
    case ($urandom_range(5, 0))
      0: return 64'hFFFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return 64'd0;
      3: return 64'($urandom_range(20, 1));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b1;
    reset = 1'b0;

    do_op(2'b00, 64'd3, 64'd5, 5'd7, 1'b1, 64'd15, 1'b0);
    do_op(2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    do_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 1'b1, 64'h0000_0000_0000_0001, 1'b0);
    do_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    do_op(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd4, 1'b1, 64'h4000_0000_0000_0000, 1'b0);
    do_op(2'b00, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    do_op(2'b11, 64'd6, 64'd7, 5'd6, 1'b1, 64'd42, 1'b0);
    do_op(2'b00, 64'd7, 64'd6, 5'd9, 1'b1, 64'd42, 1'b1);

    // Abort at CALC cycle 30 with start held across the reset edge.
    wait_idle();
    start = 1'b1; op = 2'b00; A = 64'd11; B = 64'd13; Rd = 5'd12;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    do_op(2'b00, 64'd2, 64'd2, 5'd10, 1'b1, 64'd4, 1'b0);

    for (int t = 0; t < 20; t++) begin
      do_op(2'($urandom_range(3, 0)), pick_operand(), pick_operand(), 5'($urandom),
            1'b0, 64'd0, 1'($urandom_range(1, 0)));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
